// File: rtl/token_sequencer.sv
// token_sequencer
//   Initiator side of the calculator token interface. Key codes from the
//   keypad decoder are queued in a small FIFO. Digits are accumulated into
//   a number. Operators and clear are turned into 32-bit tokens, which are
//   handed to the calculator with a strobe/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_valid    one-cycle pulse, key_code valid
//   key_code     0-9 digit, A +, B -, C *, D /, E =, F clear
//   ready        calculator idle / last token consumed
//   strobe       one-cycle token-valid pulse
//   token        number (bit31=0) or operator 32'h8000000A..F
//   disp_value   current accumulator
//   busy         FIFO non-empty or FSM not idle
//   key_drop     sticky, a key was lost to a full FIFO
//   digit_ovf    sticky, a digit was ignored because the number would exceed MAX_NUM
//
// state  | meaning
// IDLE   | pop and process one key per cycle
// STROBE | strobe high for this single cycle
// GAP    | one cycle for the calculator to drop ready; ready ignored
// WAIT   | hold until ready, then send the queued operator or return to IDLE

module token_sequencer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MAX_NUM    = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        ready,
    output logic        strobe,
    output logic [31:0] token,
    output logic [31:0] disp_value,
    output logic        busy,
    output logic        key_drop,
    output logic        digit_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] acc;
    logic        num_pending;
    logic        op_valid;
    logic [3:0]  op_code;

    logic [3:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [3:0]  head;

    logic        head_is_digit;
    logic        head_is_clear;
    logic [35:0] acc_next_wide;
    logic        digit_fits;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = key_valid && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    assign head_is_digit = (head <= 4'd9);
    assign head_is_clear = (head == 4'hF);

    // Wide enough that acc*10+9 can never wrap before the range compare.
    assign acc_next_wide = ({4'd0, acc} * 36'd10) + {32'd0, head};
    assign digit_fits    = (acc_next_wide <= {4'd0, MAX_NUM});

    assign disp_value = acc;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= key_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            strobe      <= 1'b0;
            token       <= '0;
            acc         <= '0;
            num_pending <= 1'b0;
            op_valid    <= 1'b0;
            op_code     <= '0;
            key_drop    <= 1'b0;
            digit_ovf   <= 1'b0;
        end else begin
            strobe <= 1'b0;

            // A drop in the same cycle as a clear still gets recorded.
            if (pop && head_is_clear) begin
                key_drop <= 1'b0;
            end
            if (key_valid && fifo_full) begin
                key_drop <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_is_digit) begin
                            if (digit_fits) begin
                                acc         <= acc_next_wide[31:0];
                                num_pending <= 1'b1;
                            end else begin
                                digit_ovf <= 1'b1;
                            end
                        end else if (head_is_clear) begin
                            acc         <= '0;
                            num_pending <= 1'b0;
                            digit_ovf   <= 1'b0;
                            token       <= {28'h8000000, head};
                            strobe      <= 1'b1;
                            state       <= STROBE;
                        end else begin
                            if (num_pending) begin
                                // Number goes first; operator waits for ready.
                                token       <= acc;
                                op_valid    <= 1'b1;
                                op_code     <= head;
                                acc         <= '0;
                                num_pending <= 1'b0;
                            end else begin
                                token <= {28'h8000000, head};
                            end
                            strobe <= 1'b1;
                            state  <= STROBE;
                        end
                    end
                end
                STROBE: begin
                    state <= GAP;
                end
                GAP: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (ready) begin
                        if (op_valid) begin
                            token    <= {28'h8000000, op_code};
                            op_valid <= 1'b0;
                            strobe   <= 1'b1;
                            state    <= STROBE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_token_sequencer.sv
module tb_token_sequencer;

    localparam logic [31:0] MAX_NUM = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        ready = 1'b1;
    logic        strobe;
    logic [31:0] token;
    logic [31:0] disp_value;
    logic        busy;
    logic        key_drop;
    logic        digit_ovf;

    int checks = 0;
    int errors = 0;

    // reference model state: key semantics only, expressed as a token list
    longint unsigned m_acc;
    bit              m_pend;
    bit              m_ovf;
    bit              m_drop;
    logic [31:0]     exp_q[$];

    // calculator model controls
    bit ready_man  = 1'b1;
    bit calc_mode  = 1'b0;
    bit rand_gap   = 1'b0;
    int hold_cnt   = 0;
    bit prev_strobe = 1'b0;

    token_sequencer #(.FIFO_DEPTH(4), .MAX_NUM(MAX_NUM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .ready      (ready),
        .strobe     (strobe),
        .token      (token),
        .disp_value (disp_value),
        .busy       (busy),
        .key_drop   (key_drop),
        .digit_ovf  (digit_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc  = 0;
        m_pend = 0;
        m_ovf  = 0;
        m_drop = 0;
        exp_q.delete();
    endtask

    task automatic model_key(input logic [3:0] k);
        longint unsigned t;
        if (k <= 4'd9) begin
            t = m_acc * 10 + 64'(k);
            if (t <= 64'(MAX_NUM)) begin
                m_acc  = t;
                m_pend = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (k == 4'hF) begin
            m_acc  = 0;
            m_pend = 0;
            m_ovf  = 0;
            m_drop = 0;
            exp_q.push_back(32'h8000_000F);
        end else begin
            if (m_pend) exp_q.push_back(m_acc[31:0]);
            m_acc  = 0;
            m_pend = 0;
            exp_q.push_back(32'h8000_0000 | 32'(k));
        end
    endtask

    // token monitor and calculator ready model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (strobe) begin
                chk("strobe_width", 32'(prev_strobe), 32'd0);
                if (calc_mode) chk("strobe_while_not_ready", 32'(ready), 32'd1);
                if (exp_q.size() > 0) chk("token", token, exp_q.pop_front());
                else chk("token_extra", 32'(exp_q.size()), 32'd1);
            end
            prev_strobe = strobe;
        end else begin
            prev_strobe = 1'b0;
        end
        if (calc_mode) begin
            if (strobe && rst_n === 1'b1) begin
                hold_cnt = rand_gap ? $urandom_range(0, 5) : 5;
                ready    = (hold_cnt == 0);
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) ready = 1'b1;
            end
        end else begin
            ready    = ready_man;
            hold_cnt = 0;
        end
    end

    task automatic send_key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic send_model(input logic [3:0] k);
        model_key(k);
        send_key(k);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_tokens_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_disp"}, disp_value, m_acc[31:0]);
        chk({tag, "_ovf"}, 32'(digit_ovf), 32'(m_ovf));
        chk({tag, "_drop"}, 32'(key_drop), 32'(m_drop));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] digs [10];
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_strobe", 32'(strobe), 32'd0);
        chk("rst_token", token, 32'd0);
        chk("rst_disp", disp_value, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(key_drop), 32'd0);
        chk("rst_ovf", 32'(digit_ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // number then operator, ready tied high
        ready_man = 1'b1;
        send_model(4'd1);
        send_model(4'd8);
        repeat (3) @(negedge clk);
        chk("t1_disp18", disp_value, 32'd18);
        send_model(4'hA);
        send_model(4'd9);
        send_model(4'hE);
        wait_idle();
        end_checks("t1");

        // calculator drops ready for 5 cycles after each strobe
        calc_mode = 1'b1;
        rand_gap  = 1'b0;
        send_model(4'hF);
        send_model(4'd7);
        send_model(4'hB);
        send_model(4'd8);
        wait_idle();
        send_model(4'hD);
        send_model(4'd4);
        send_model(4'hE);
        wait_idle();
        end_checks("t2");
        calc_mode = 1'b0;
        repeat (2) @(negedge clk);

        // digit overflow at MAX_NUM
        digs = '{4'd2, 4'd1, 4'd4, 4'd7, 4'd4, 4'd8, 4'd3, 4'd6, 4'd4, 4'd7};
        for (int i = 0; i < 10; i++) send_model(digs[i]);
        send_model(4'd8);
        wait_idle();
        chk("t3_disp_max", disp_value, 32'd2147483647);
        chk("t3_ovf", 32'(digit_ovf), 32'd1);
        send_model(4'hE);
        wait_idle();
        end_checks("t3");

        // FIFO fills while ready is held low
        ready_man = 1'b0;
        send_model(4'hE);
        repeat (6) @(negedge clk);
        model_key(4'd1);
        model_key(4'd2);
        model_key(4'hA);
        model_key(4'd3);
        m_drop = 1;
        send_key(4'd1);
        send_key(4'd2);
        send_key(4'hA);
        send_key(4'd3);
        send_key(4'hB);
        send_key(4'd4);
        repeat (4) @(negedge clk);
        chk("t4_drop", 32'(key_drop), 32'd1);
        chk("t4_busy_stalled", 32'(busy), 32'd1);
        ready_man = 1'b1;
        wait_idle();
        end_checks("t4a");
        send_model(4'hF);
        wait_idle();
        end_checks("t4b");

        // leading operators and clear discarding a pending number
        send_model(4'hC);
        send_model(4'hE);
        wait_idle();
        send_model(4'd5);
        send_model(4'hF);
        wait_idle();
        end_checks("t5");

        // randomized bursts against the calculator model
        calc_mode = 1'b1;
        rand_gap  = 1'b1;
        for (int b = 0; b < 60; b++) begin
            int n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                logic [3:0] k;
                k = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 9))
                                                : 4'($urandom_range(10, 15));
                send_model(k);
            end
            wait_idle();
            end_checks("rand");
        end
        calc_mode = 1'b0;
        ready_man = 1'b0;
        repeat (8) @(negedge clk);

        // reset while waiting with an operator queued behind a number
        send_model(4'hF);
        ready_man = 1'b1;
        wait_idle();
        ready_man = 1'b0;
        exp_q.push_back(32'd5);
        send_key(4'd5);
        send_key(4'hA);
        repeat (8) @(negedge clk);
        chk("t6_busy_waiting", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_strobe", 32'(strobe), 32'd0);
        chk("t6_rst_token", token, 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_tokens_seen", 32'(exp_q.size()), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        ready_man = 1'b1;
        repeat (12) @(negedge clk);
        chk("t6_busy_after", 32'(busy), 32'd0);
        end_checks("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
